// File: rtl/demod_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// demod_seq_pkg : shared types and widths for the run sequencer
// Rev 1.0
// ============================================================
package demod_seq_pkg;

  localparam int C_TBL_DEPTH   = 16;
  localparam int C_ADDR_W      = 14;
  localparam int C_DATA_W      = 33;
  localparam int C_TMO_W       = 24;
  localparam int SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_FIRE   = 3'd3,
    S_WAIT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [C_ADDR_W-1:0] addr;
    logic [C_DATA_W-1:0] data;
  } cfg_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demod_seq_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// demod_seq_ctrl_if : host config port in, datapath config port out
// Rev 1.0
// ============================================================
interface demod_seq_ctrl_if
  import demod_seq_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
);

  logic [ADDR_W-1:0] host_address;
  logic              host_wrEn;
  logic [DATA_W-1:0] host_wrData;
  logic [ADDR_W-1:0] cfg_address;
  logic              cfg_wrEn;
  logic [DATA_W-1:0] cfg_wrData;

  modport master (
    output host_address, host_wrEn, host_wrData,
    input  cfg_address, cfg_wrEn, cfg_wrData
  );

  modport slave (
    input  host_address, host_wrEn, host_wrData,
    output cfg_address, cfg_wrEn, cfg_wrData
  );

endinterface
`default_nettype wire

// File: rtl/seq_cfg_table.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// seq_cfg_table : config-write table, 1 write / 1 async read, no reset
// Rev 1.0
// ============================================================
module seq_cfg_table #(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 47,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/demod_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================
// demod_seq_ctrl : run sequencer and config-port arbiter
// Rev 1.0
// ============================================================
module demod_seq_ctrl
  import demod_seq_pkg::*;
#(
  parameter int  TBL_DEPTH = C_TBL_DEPTH,
  parameter int  ADDR_W    = C_ADDR_W,
  parameter int  DATA_W    = C_DATA_W,
  parameter int  TMO_W     = C_TMO_W,
  localparam int IDX_W     = $clog2(TBL_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demod_seq_ctrl_if.slave          bus,
  input  logic                     i_tbl_wr_en,
  input  logic [IDX_W-1:0]         i_tbl_wr_addr,
  input  logic [ADDR_W+DATA_W-1:0] i_tbl_wr_data,
  input  logic [IDX_W:0]           i_tbl_len,
  input  logic [15:0]              i_num_shots,
  input  logic [15:0]              i_num_data_pts,
  input  logic [TMO_W-1:0]         i_timeout_cycles,
  input  logic                     i_hvi_start,
  input  logic                     i_hvi_abort,
  input  logic                     i_iq_valid,
  output logic                     o_demod_trigger,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout_err,
  output logic                     o_host_blocked,
  output logic [15:0]              o_shot_count
);

  state_t                   r_state, w_next;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W:0]           r_tbl_len;
  logic [15:0]              r_num_shots, r_num_pts, r_pts, r_shot;
  logic [TMO_W-1:0]         r_tmo, r_wait, w_wait_inc;
  logic [2:0]               r_settle;
  logic [ADDR_W+DATA_W-1:0] w_rd_data;
  logic [15:0]              w_pts_inc, w_shot_inc;
  logic w_start, w_abort, w_shot_done, w_tmo_hit, w_load_last, w_settle_done, w_tbl_we;

  logic                     r_cfg_we, r_trig, r_done, r_busy, r_tmo_err, r_host_blk;
  logic [ADDR_W-1:0]        r_cfg_addr, w_cfg_addr;
  logic [DATA_W-1:0]        r_cfg_data, w_cfg_data;
  logic                     w_cfg_we, w_trig, w_done;

  assign w_tbl_we = i_tbl_wr_en && (r_state == S_IDLE);

  seq_cfg_table #(
    .DEPTH (TBL_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_tbl (
    .clk       (clk),
    .i_wr_en   (w_tbl_we),
    .i_wr_addr (i_tbl_wr_addr),
    .i_wr_data (i_tbl_wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  // Abort beats a coincident start in IDLE, so the run never begins
  assign w_start       = (r_state == S_IDLE) && i_hvi_start && !i_hvi_abort;
  assign w_abort       = (r_state != S_IDLE) && i_hvi_abort;
  assign w_pts_inc     = i_iq_valid ? sat_inc16(r_pts) : r_pts;
  assign w_shot_inc    = sat_inc16(r_shot);
  assign w_wait_inc    = (&r_wait) ? r_wait : r_wait + TMO_W'(1);
  assign w_shot_done   = (r_state == S_WAIT) && (w_pts_inc >= r_num_pts);
  assign w_tmo_hit     = (r_state == S_WAIT) && (r_tmo != '0) && (w_wait_inc == r_tmo);
  assign w_load_last   = ({1'b0, r_idx} == (r_tbl_len - (IDX_W+1)'(1)));
  assign w_settle_done = (r_settle == 3'(SETTLE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (i_num_shots == '0)    w_next = S_DONE;
          else if (i_tbl_len == '0) w_next = S_SETTLE;
          else                      w_next = S_LOAD;
        end
      end
      S_LOAD:   if (w_load_last)   w_next = S_SETTLE;
      S_SETTLE: if (w_settle_done) w_next = S_FIRE;
      S_FIRE:   w_next = S_WAIT;
      S_WAIT: begin
        // Completion takes priority over a timeout in the same cycle
        if (w_shot_done)    w_next = (w_shot_inc < r_num_shots) ? S_SETTLE : S_DONE;
        else if (w_tmo_hit) w_next = S_DONE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_comb begin
    w_cfg_we   = 1'b0;
    w_cfg_addr = r_cfg_addr;
    w_cfg_data = r_cfg_data;
    w_trig     = 1'b0;
    w_done     = 1'b0;
    if (!w_abort) begin
      case (r_state)
        S_IDLE: begin
          w_cfg_we   = bus.host_wrEn;
          w_cfg_addr = bus.host_address;
          w_cfg_data = bus.host_wrData;
        end
        S_LOAD: begin
          w_cfg_we   = 1'b1;
          w_cfg_addr = w_rd_data[ADDR_W+DATA_W-1 -: ADDR_W];
          w_cfg_data = w_rd_data[DATA_W-1:0];
        end
        S_FIRE:  w_trig = 1'b1;
        S_DONE:  w_done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_we    <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_trig      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_host_blk  <= 1'b0;
      r_shot      <= '0;
      r_idx       <= '0;
      r_tbl_len   <= '0;
      r_num_shots <= '0;
      r_num_pts   <= '0;
      r_tmo       <= '0;
      r_pts       <= '0;
      r_wait      <= '0;
      r_settle    <= '0;
    end else begin
      r_cfg_we   <= w_cfg_we;
      r_cfg_addr <= w_cfg_addr;
      r_cfg_data <= w_cfg_data;
      r_trig     <= w_trig;
      r_done     <= w_done;
      r_busy     <= (w_next != S_IDLE);
      if (w_start) begin
        r_tbl_len   <= i_tbl_len;
        r_num_shots <= i_num_shots;
        r_num_pts   <= i_num_data_pts;
        r_tmo       <= i_timeout_cycles;
        r_shot      <= '0;
        r_tmo_err   <= 1'b0;
        r_host_blk  <= 1'b0;
        r_idx       <= '0;
      end else begin
        if ((r_state != S_IDLE) && bus.host_wrEn) r_host_blk <= 1'b1;
        if (r_state == S_LOAD) r_idx <= r_idx + IDX_W'(1);
        if (!w_abort) begin
          if (w_shot_done)    r_shot    <= w_shot_inc;
          else if (w_tmo_hit) r_tmo_err <= 1'b1;
        end
      end
      r_settle <= (r_state == S_SETTLE) ? r_settle + 3'd1 : 3'd0;
      if (r_state == S_FIRE) begin
        r_pts  <= '0;
        r_wait <= '0;
      end else if (r_state == S_WAIT) begin
        r_pts  <= w_pts_inc;
        r_wait <= w_wait_inc;
      end
    end
  end

  assign bus.cfg_wrEn    = r_cfg_we;
  assign bus.cfg_address = r_cfg_addr;
  assign bus.cfg_wrData  = r_cfg_data;
  assign o_demod_trigger = r_trig;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_timeout_err   = r_tmo_err;
  assign o_host_blocked  = r_host_blk;
  assign o_shot_count    = r_shot;

endmodule
`default_nettype wire

// File: doc/demod_seq_ctrl.md
# demod_seq_ctrl

Run sequencer and config-port arbiter for the demod datapath. On an HVI start pulse it streams a preloaded table of register writes into the datapath config port, then fires `num_shots` demod triggers, waiting after each one for `num_data_pts` IQ results or a timeout. It sits between the PC/HVI ports and the demod top, owning the datapath MEM write port and `trigger_in[0]`.

## Interface
- `TBL_DEPTH`, 16: config table entries (power of two).
- `ADDR_W`, 14: config address width.
- `DATA_W`, 33: config data width.
- `TMO_W`, 24: timeout counter width.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: reset, asynchronous, active-low.
- `host_address`/`host_wrEn`/`host_wrData` in ADDR_W/1/DATA_W: PC-port config write.
- `tbl_wr_en` in 1, `tbl_wr_addr` in log2(TBL_DEPTH), `tbl_wr_data` in ADDR_W+DATA_W: table load, `{addr,data}`.
- `tbl_len` in log2(TBL_DEPTH)+1: number of table entries to issue per run (0..TBL_DEPTH).
- `num_shots` in 16, `num_data_pts` in 16, `timeout_cycles` in TMO_W: run parameters, sampled at start.
- `hvi_start` in 1, `hvi_abort` in 1: single-cycle control pulses.
- `iq_valid` in 1: one IQ result from the datapath.
- `cfg_address`/`cfg_wrEn`/`cfg_wrData` out ADDR_W/1/DATA_W: registered datapath config port.
- `demod_trigger` out 1: shot trigger, one cycle wide.
- `busy` out 1, `done` out 1 (one-cycle pulse), `timeout_err` out 1 (sticky), `host_blocked` out 1 (sticky).
- `shot_count` out 16: number of completed shots in the current or last run.

## Operation
- States: IDLE, LOAD, SETTLE, FIRE, WAIT, DONE.
- IDLE: `host_*` passes to `cfg_*` through one register. `hvi_start` latches the run parameters, clears `shot_count`, `timeout_err` and `host_blocked`, then moves to LOAD. If `tbl_len`==0 it moves to SETTLE instead. If `num_shots`==0 it moves to DONE.
- LOAD: issues table entries 0..`tbl_len`-1, one per cycle, with `cfg_wrEn`=1. After the last entry it moves to SETTLE.
- SETTLE: waits `SETTLE_CYCLES`=4 cycles with no writes, then moves to FIRE.
- FIRE: `demod_trigger`=1 for one cycle. Clears the point and timeout counters, then moves to WAIT.
- WAIT: counts `iq_valid`. When the count reaches the latched `num_data_pts`:
  - `shot_count`++.
  - If `shot_count` < `num_shots`, go to SETTLE; otherwise go to DONE.
  - `num_data_pts`==0 completes the shot on the first WAIT cycle.
- Timeout: when the WAIT cycle counter equals a nonzero `timeout_cycles`, set `timeout_err` and go to DONE. If `iq_valid` completes the shot in the same cycle, completion wins. `timeout_cycles`==0 disables the timeout.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- While busy, any `host_wrEn` is dropped and sets `host_blocked`. `tbl_wr_en` while busy is ignored. `hvi_start` while busy is ignored.
- `hvi_abort` in any non-IDLE state:
  - next state IDLE;
  - `cfg_wrEn` and `demod_trigger` forced to 0 from the next cycle;
  - no `done` pulse; `shot_count` holds its value.
- `hvi_start` and `hvi_abort` in the same cycle in IDLE: abort wins and the run does not start.
- Counters saturate at their width and never wrap.

## Timing
- Reset: every output is 0 and the state is IDLE. Table contents are not reset.
- Host pass-through latency: 1 cycle (`host_wrEn` at edge N appears as `cfg_wrEn` after edge N+1).
- `hvi_start` sampled at edge E0: table entry k appears on `cfg_*` in cycle E0+1+k.
- `demod_trigger` is high in cycle E0+1+`tbl_len`+4.
- Shot completion: the `iq_valid` that reaches the count at edge W gives SETTLE at W+1. The next trigger follows 4 cycles later, at W+5.
- `done` is high in the cycle after the final completion or timeout edge.

## Structure
- Package `demod_seq_pkg` holds:
  - the state enum;
  - `SETTLE_CYCLES`;
  - the table entry struct `{addr, data}`;
  - the width localparams.
- Sub-module `seq_cfg_table`: TBL_DEPTH × (ADDR_W+DATA_W) register file with 1 write port and 1 combinational read port. Contents are not reset.
- Top module holds the FSM, the counters and the output registers.

## Test plan
- Reset mid-LOAD (entry 2 of 5): all outputs 0 immediately, FSM in IDLE, a new start succeeds.
- `tbl_len`=3, `num_shots`=2, `num_data_pts`=4, `timeout_cycles`=0:
  - writes on cycles E0+1..+3;
  - triggers at E0+8 and 5 cycles after the 4th `iq_valid`;
  - `done` once, `shot_count`=2.
- `timeout_cycles`=10, no `iq_valid`: `timeout_err`=1, `done` pulse, `shot_count`=0. With `iq_valid` completing on the timeout cycle: `timeout_err`=0.
- `num_shots`=0: `done` on E0+1, no `cfg_wrEn`, no trigger. `tbl_len`=0, `num_data_pts`=0: back-to-back triggers every 6 cycles.
- `host_wrEn` while busy: no `cfg_wrEn`, `host_blocked`=1. After IDLE, host write addr 0x12/data 5 appears 1 cycle later.
- `hvi_abort` during WAIT of shot 2: `busy`=0 next cycle, no `done`, `shot_count`=1. Simultaneous start+abort in IDLE: stays IDLE.
